// File: rtl/ppm_final_adder.sv
// Two-stage carry-propagate adder that resolves the PPM redundant pair into a W-bit product.
// Optional output-transfer counter enabled by defining PPM_FA_STATS_EN.
module ppm_final_adder #(
    parameter int unsigned N     = 4,
    parameter int unsigned M     = 4,
    parameter int unsigned SPLIT = (N + M) / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N+M-1:0]   in_op1,
    input  logic [N+M-1:0]   in_op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N+M-1:0]   out_sum
`ifdef PPM_FA_STATS_EN
    ,
    output logic [15:0]      res_count
`endif
);

    localparam int unsigned W  = N + M;
    localparam int unsigned HW = W - SPLIT;

    if (SPLIT < 1 || SPLIT > W - 1) begin : g_bad_split
        $fatal(1, "ppm_final_adder: SPLIT=%0d outside 1..%0d", SPLIT, W - 1);
    end

    // Handshake / advance control
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_en, s2_en;

    always_comb begin
        s2_en      = !s2_valid_q || out_ready;
        s1_en      = !s1_valid_q || s2_en;
        s1_valid_d = s1_en ? (in_valid && s1_en) : s1_valid_q;
        s2_valid_d = s2_en ? s1_valid_q : s2_valid_q;
    end

    assign in_ready  = s1_en;
    assign out_valid = s2_valid_q;

    // Stage 1: low chunk sum with carry, upper slices held for stage 2
    logic [SPLIT-1:0] lo_q, lo_d;
    logic             c_q, c_d;
    logic [HW-1:0]    hi1_q, hi1_d;
    logic [HW-1:0]    hi2_q, hi2_d;
    logic [SPLIT:0]   lo_full;

    always_comb begin
        lo_full = {1'b0, in_op1[SPLIT-1:0]} + {1'b0, in_op2[SPLIT-1:0]};
        lo_d    = lo_q;
        c_d     = c_q;
        hi1_d   = hi1_q;
        hi2_d   = hi2_q;
        // Data registers load whenever the stage advances; s1_valid gates use.
        if (s1_en) begin
            lo_d  = lo_full[SPLIT-1:0];
            c_d   = lo_full[SPLIT];
            hi1_d = in_op1[W-1:SPLIT];
            hi2_d = in_op2[W-1:SPLIT];
        end
    end

    // Stage 2: upper chunk absorbs the stage-1 carry; carry-out above W is dropped
    logic [W-1:0]  sum_q, sum_d;
    logic [HW-1:0] hi_sum;

    always_comb begin
        hi_sum = hi1_q + hi2_q + HW'(c_q);
        sum_d  = s2_en ? {hi_sum, lo_q} : sum_q;
    end

    assign out_sum = sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            lo_q       <= '0;
            c_q        <= 1'b0;
            hi1_q      <= '0;
            hi2_q      <= '0;
            sum_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            lo_q       <= lo_d;
            c_q        <= c_d;
            hi1_q      <= hi1_d;
            hi2_q      <= hi2_d;
            sum_q      <= sum_d;
        end
    end

`ifdef PPM_FA_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (s2_valid_q && out_ready) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign res_count = cnt_q;
`endif

    // A stalled result must not change under backpressure.
    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_sum)));

    a_ready_when_free: assert property (@(posedge clk) disable iff (!rst_n)
        (!s1_valid_q || !s2_valid_q) |-> in_ready);

endmodule
